axis_pkt_rr_arbiter: RTL and testbench
======================================

Name: axis_pkt_rr_arbiter

Overview:
- Packet-level round-robin arbiter and mux in front of the shared AXI-stream FIFO.
- Shares one FIFO write port among PORTS requesters on a single clock domain.
- Once a port is granted, it holds the grant for the whole packet, up to and including its tlast beat. Beats are never interleaved.
- Has a registered output stage. m_axis_tid carries the source port index so the FIFO consumer can demultiplex.

Parameters:
- PORTS, 4, number of slave requesters (2..16).
- DATA_WIDTH, 8, tdata width per port.
- KEEP_WIDTH, (DATA_WIDTH+7)/8, tkeep width per port.
- ID_WIDTH, $clog2(PORTS), width of m_axis_tid and grant_index.

Ports:
- s_axis_aclk  in  1  single clock for all interfaces
- s_axis_aresetn  in  1  synchronous active-low reset
- s_axis_tvalid  in  PORTS  per-port valid
- s_axis_tready  out  PORTS  per-port ready
- s_axis_tdata  in  PORTS*DATA_WIDTH  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tkeep  in  PORTS*KEEP_WIDTH  port i occupies bits [i*KEEP_WIDTH +: KEEP_WIDTH]
- s_axis_tlast  in  PORTS  per-port last
- m_axis_tvalid  out  1  to FIFO write side
- m_axis_tready  in  1  from FIFO (for example, not full)
- m_axis_tdata  out  DATA_WIDTH
- m_axis_tkeep  out  KEEP_WIDTH
- m_axis_tlast  out  1
- m_axis_tid  out  ID_WIDTH  source port of the current output beat
- busy  out  1  high while in ACTIVE
- grant_index  out  ID_WIDTH  currently or last granted port

Behaviour:
- Clock and reset: one clock, s_axis_aclk. Reset s_axis_aresetn is synchronous and active-low.
- Reset values:
  - state = IDLE
  - m_axis_tvalid = 0; m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid = 0
  - grant_index = PORTS-1, so port 0 wins first
  - busy = 0; s_axis_tready = all 0
- Output stage:
  - out_ready = !m_axis_tvalid || m_axis_tready.
  - On a slave transfer, the output register loads {tdata, tkeep, tlast, grant_index} and m_axis_tvalid is set to 1.
  - Otherwise, if m_axis_tready is high, m_axis_tvalid is cleared.
  - Output data is held stable while m_axis_tvalid=1 and m_axis_tready=0.
- s_axis_tready[i] = (state==ACTIVE) && (grant_index==i) && out_ready. This is combinational from m_axis_tready. All other bits are 0.
- Latency: a beat accepted in cycle N appears on the m_axis outputs in cycle N+1.
- IDLE state:
  - If any s_axis_tvalid bit is set, select the first set bit searching upward from grant_index+1 and wrapping modulo PORTS.
  - Register the selection into grant_index and move to ACTIVE.
  - This costs one arbitration cycle with no slave transfer.
  - If no tvalid bit is set, remain in IDLE and leave grant_index unchanged.
- ACTIVE state:
  - Accept beats only from grant_index.
  - On a transfer with s_axis_tlast=1, return to IDLE in the next cycle.
  - The grant is not released if the granted port drops tvalid mid-packet. The arbiter waits indefinitely.
- Fairness: each port gets at most one packet per round while other ports are requesting.
- A requester's own repeat request is served only after all other pending ports have been served.
- busy = (state==ACTIVE).
- Simultaneous events: a request that appears in the same cycle as a tlast transfer is arbitrated in the following IDLE cycle. The minimum inter-packet gap on the slave side is therefore 1 cycle.
- Single-beat packet: arbitration cycle, then one transfer, then IDLE. The sequence repeats every 2 cycles.
- Reset asserted mid-packet:
  - Returns all state to reset values within 1 cycle and drops the buffered output beat.
  - The FIFO may then see a truncated packet. This is accepted; the FIFO shares the same reset.
- Backpressure: m_axis_tready=0 with m_axis_tvalid=1 forces all s_axis_tready to 0. No beat is lost or duplicated.

Test Plan:
1. Reset, then port 2 alone sends a 3-beat packet with tdata 0x11, 0x22, 0x33 -> after 1 arbitration cycle, m_axis shows 0x11, 0x22, 0x33 on consecutive cycles with tid=2 and tlast only on 0x33. busy=1 during the packet.
2. All 4 ports continuously send 2-beat packets -> grant order is 0,1,2,3,0,1. No interleaving. Each packet keeps a constant m_axis_tid.
3. Port 1 active with ports 0 and 3 pending, port 1 ends its packet -> next grant is 3, then 0.
4. Hold m_axis_tready=0 for 5 cycles mid-packet -> m_axis_tdata is held stable. s_axis_tready=0 throughout. The sequence resumes with no loss or duplication.
5. Granted port deasserts tvalid for 3 cycles mid-packet while port 0 requests -> grant is held and no port 0 beats appear before the tlast of the granted port.
6. Assert s_axis_aresetn=0 for 1 cycle mid-packet -> next cycle shows m_axis_tvalid=0, busy=0, grant_index=PORTS-1. The following arbitration grants the lowest requesting port.

Source files
------------

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-level round-robin arbiter and mux feeding one AXI-stream FIFO write port.
// A granted port keeps the grant until its tlast beat; output stage is a single register slice.
module axis_pkt_rr_arbiter #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int ID_WIDTH   = $clog2(PORTS)
) (
    input  logic                        s_axis_aclk,
    input  logic                        s_axis_aresetn,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    output logic [PORTS-1:0]            s_axis_tready,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [PORTS-1:0]            s_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic [ID_WIDTH-1:0]         m_axis_tid,
    output logic                        busy,
    output logic [ID_WIDTH-1:0]         grant_index
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                  state_q;
    logic [ID_WIDTH-1:0]     grant_q;
    logic [ID_WIDTH-1:0]     grant_d;
    logic                    m_valid_q;
    logic [DATA_WIDTH-1:0]   m_data_q;
    logic [KEEP_WIDTH-1:0]   m_keep_q;
    logic                    m_last_q;
    logic [ID_WIDTH-1:0]     m_tid_q;

    logic                    out_ready;
    logic                    xfer;
    logic [DATA_WIDTH-1:0]   port_data [PORTS];
    logic [KEEP_WIDTH-1:0]   port_keep [PORTS];
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [KEEP_WIDTH-1:0]   sel_keep;
    logic                    sel_valid;
    logic                    sel_last;

    // Search upward from the port after the last grant, wrapping modulo PORTS.
    function automatic logic [ID_WIDTH-1:0] rr_pick(
        input logic [PORTS-1:0]    req,
        input logic [ID_WIDTH-1:0] last
    );
        logic [ID_WIDTH-1:0] pick;
        logic [ID_WIDTH:0]   sum;
        logic                found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= PORTS; k++) begin
            sum = {1'b0, last} + (ID_WIDTH+1)'(k);
            if (sum >= (ID_WIDTH+1)'(PORTS)) begin
                sum = sum - (ID_WIDTH+1)'(PORTS);
            end
            if (!found && req[sum[ID_WIDTH-1:0]]) begin
                found = 1'b1;
                pick  = sum[ID_WIDTH-1:0];
            end
        end
        return pick;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_port
            assign port_data[gi]     = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign port_keep[gi]     = s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
            assign s_axis_tready[gi] = (state_q == ST_ACTIVE) && (grant_q == ID_WIDTH'(gi)) && out_ready;
        end
    endgenerate

    assign out_ready = !m_valid_q || m_axis_tready;
    assign sel_data  = port_data[grant_q];
    assign sel_keep  = port_keep[grant_q];
    assign sel_valid = s_axis_tvalid[grant_q];
    assign sel_last  = s_axis_tlast[grant_q];
    assign xfer      = (state_q == ST_ACTIVE) && sel_valid && out_ready;
    assign grant_d   = rr_pick(s_axis_tvalid, grant_q);

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            state_q   <= ST_IDLE;
            grant_q   <= ID_WIDTH'(PORTS - 1);
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_tid_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant_q <= grant_d;
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (xfer && sel_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Output slice: load on transfer, drain when the FIFO accepts.
            if (xfer) begin
                m_valid_q <= 1'b1;
                m_data_q  <= sel_data;
                m_keep_q  <= sel_keep;
                m_last_q  <= sel_last;
                m_tid_q   <= grant_q;
            end else if (m_axis_tready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tid    = m_tid_q;
    assign busy          = (state_q == ST_ACTIVE);
    assign grant_index   = grant_q;

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Randomized bench for axis_pkt_rr_arbiter against a queue-based transaction model.
module tb_axis_pkt_rr_arbiter;

    localparam int P  = 4;
    localparam int DW = 8;
    localparam int KW = 1;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            aresetn;
    logic [P-1:0]    s_tvalid;
    logic [P-1:0]    s_tready;
    logic [P*DW-1:0] s_tdata;
    logic [P*KW-1:0] s_tkeep;
    logic [P-1:0]    s_tlast;
    logic            m_tvalid;
    logic            m_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic [IW-1:0]   m_tid;
    logic            busy;
    logic [IW-1:0]   grant_index;

    axis_pkt_rr_arbiter #(
        .PORTS(P), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW)
    ) dut (
        .s_axis_aclk   (clk),
        .s_axis_aresetn(aresetn),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tid    (m_tid),
        .busy          (busy),
        .grant_index   (grant_index)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-port packet generators
    int            left  [P];
    logic [DW-1:0] gdata [P];
    logic [KW-1:0] gkeep [P];
    bit            gvalid[P];

    // Reference model: one pending output beat at most, queue-held
    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        int            id;
    } beat_t;
    beat_t oq[$];
    bit    mdl_active;
    int    mdl_port;
    int    mdl_last;

    function automatic int rr_next(input int last, input bit req[P]);
        for (int k = 1; k <= P; k++) begin
            if (req[(last + k) % P]) return (last + k) % P;
        end
        return last;
    endfunction

    task automatic pack_inputs();
        for (int p = 0; p < P; p++) begin
            s_tvalid[p]         = gvalid[p];
            s_tdata[p*DW +: DW] = gdata[p];
            s_tkeep[p*KW +: KW] = gkeep[p];
            s_tlast[p]          = (left[p] == 1);
        end
    endtask

    task automatic fresh_beat(input int p, input bit new_pkt);
        if (new_pkt) left[p] = $urandom_range(1, 4);
        else         left[p] = left[p] - 1;
        gdata[p] = DW'($urandom);
        gkeep[p] = KW'($urandom);
    endtask

    task automatic run(input int cycles, input int vpct, input int rpct, input int rst_pm, input bit mask[P]);
        bit            any_req;
        bit            req[P];
        bit            xfer;
        bit            rst;
        bit            outrdy;
        int            xport;
        logic [P-1:0]  exp_rdy;
        beat_t         b;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check_eq("m_tvalid", m_tvalid, oq.size() > 0);
            if (oq.size() > 0) begin
                check_eq("m_tdata", m_tdata, oq[0].d);
                check_eq("m_tkeep", m_tkeep, oq[0].k);
                check_eq("m_tlast", m_tlast, oq[0].l);
                check_eq("m_tid",   m_tid,   oq[0].id);
            end
            check_eq("busy", busy, mdl_active);
            check_eq("grant_index", grant_index, mdl_last);
            outrdy = (oq.size() == 0) || m_tready;
            for (int p = 0; p < P; p++) begin
                exp_rdy[p] = mdl_active && (p == mdl_port) && outrdy;
                req[p]     = gvalid[p];
            end
            check_eq("s_tready", s_tready, exp_rdy);
            any_req = 1'b0;
            for (int p = 0; p < P; p++) any_req |= req[p];
            xport = mdl_port;
            xfer  = mdl_active && gvalid[xport] && outrdy;
            rst   = !aresetn;

            @(posedge clk);
            if (rst) begin
                oq.delete();
                mdl_active = 1'b0;
                mdl_last   = P - 1;
                mdl_port   = P - 1;
            end else begin
                if (oq.size() > 0 && m_tready) void'(oq.pop_front());
                if (mdl_active) begin
                    if (xfer) begin
                        b.d  = gdata[xport];
                        b.k  = gkeep[xport];
                        b.l  = (left[xport] == 1);
                        b.id = xport;
                        oq.push_back(b);
                        if (b.l) mdl_active = 1'b0;
                    end
                end else if (any_req) begin
                    mdl_port   = rr_next(mdl_last, req);
                    mdl_last   = mdl_port;
                    mdl_active = 1'b1;
                end
            end

            #1;
            for (int p = 0; p < P; p++) begin
                if (rst) begin
                    fresh_beat(p, 1'b1);
                    gvalid[p] = mask[p] && ($urandom_range(0, 99) < vpct);
                end else if (xfer && p == xport) begin
                    fresh_beat(p, left[p] == 1);
                    gvalid[p] = mask[p] && ($urandom_range(0, 99) < vpct);
                end else if (!gvalid[p]) begin
                    gvalid[p] = mask[p] && ($urandom_range(0, 99) < vpct);
                end
            end
            m_tready = ($urandom_range(0, 99) < rpct);
            aresetn  = !($urandom_range(0, 999) < rst_pm);
            pack_inputs();
        end
    endtask

    initial begin
        bit m_p2[P];
        bit m_all[P];
        bit m_013[P];
        for (int p = 0; p < P; p++) begin
            left[p]   = 0;
            gvalid[p] = 1'b0;
            fresh_beat(p, 1'b1);
            m_p2[p]   = (p == 2);
            m_all[p]  = 1'b1;
            m_013[p]  = (p != 2);
        end
        mdl_active = 1'b0;
        mdl_last   = P - 1;
        mdl_port   = P - 1;
        aresetn    = 1'b0;
        m_tready   = 1'b1;
        pack_inputs();
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;

        run(60,   100, 100, 0,  m_p2);
        run(200,  100, 100, 0,  m_all);
        run(1500, 70,  75,  0,  m_all);
        run(400,  40,  30,  0,  m_013);
        run(1000, 80,  80,  15, m_all);
        run(20,   0,   100, 0,  m_all);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
